normalize_seq: RTL and testbench
================================

// Module: normalize_seq
// PURPOSE
//   Multi-cycle normalizer feeding the rounding stage of the fp add/sub datapath.
//   Takes raw sign/exponent/significand from the significand adder.
//   Shifts the significand until its MSB (hidden bit, 2^exp) is 1, adjusting the exponent.
//   Outputs the normalized value to round over a valid/ready handshake.
// PARAMETERS
//   INTn      32   width of in_sig/out_sig (must match round INTn)
//   NEXP       8   exponent field width; exponent ports are NEXP+2 bits signed
//   NSIG      23   stored fraction bits (10/23/52/112)
//   COARSE     8   coarse left-shift step size, 1 < COARSE < INTn
//   localparam EMIN = 2-2**(NEXP-1); EXP_FLOOR = EMIN-NSIG-2
// PORTS
//   clk        in   1          clock, all state on rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          input beat valid
//   in_ready   out  1          block can accept a beat
//   in_neg     in   1          sign of result
//   in_carry   in   1          adder carry-out (bit INTn of the raw sum)
//   in_exp     in   NEXP+2     signed exponent of in_sig[INTn-1]
//   in_sig     in   INTn       raw significand
//   out_valid  out  1          normalized beat valid
//   out_ready  in   1          round stage accepts beat
//   out_neg    out  1          registered in_neg
//   out_exp    out  NEXP+2     signed exponent of out_sig[INTn-1]
//   out_sig    out  INTn       normalized significand
//   out_zero   out  1          significand is exactly zero
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid/out_neg/out_zero=0; out_exp/out_sig=0.
//   FSM IDLE -> SHIFT -> HOLD -> IDLE. in_ready=1 only in IDLE.
//   IDLE: on in_valid, load regs and go SHIFT. Load rules:
//     - in_carry=1: sig={1'b1,in_sig[INTn-1:1]} with bit0 |= in_sig[0] (sticky); exp=in_exp+1.
//     - else sig=in_sig, exp=in_exp.
//   SHIFT: exactly one action per cycle, in priority order:
//     - sig==0: out_zero=1; exp held; go HOLD.
//     - sig[INTn-1]=1 or exp==EXP_FLOOR: go HOLD.
//     - top COARSE bits zero and exp-COARSE>=EXP_FLOOR: sig<<=COARSE; exp-=COARSE.
//     - else: sig<<=1; exp-=1.
//   HOLD: out_valid=1; outputs stable until out_ready=1; that cycle returns IDLE.
//     - out_valid drops the next cycle; no back-to-back overlap.
//   Latency, accept edge to out_valid: N+1 cycles; N = shift steps taken (0 when already normalized).
//   Shift steps never take the exponent below EXP_FLOOR.
//     - Bits left unnormalized at the floor are handled by round as subnormal/sticky.
//   Left shifts insert zeros; bits shifted out are always zero.
//   No arithmetic wrap: EXP_FLOOR-1 and max in_exp+1 both fit in NEXP+2 signed bits.
//   in_valid/in_* are ignored outside IDLE. Upstream must hold them until in_ready.
//   rst_n low mid-operation: beat discarded, all outputs to reset values immediately (async).
// TESTING (INTn=32, NEXP=8, NSIG=23, COARSE=8; EXP_FLOOR=-151)
//   sig=0x8000_0000, exp=0, carry=0 -> out_valid 1 cycle after accept; sig unchanged; exp=0.
//   sig=0x0000_0001, exp=0 -> 3 coarse + 7 fine steps; latency 11; sig=0x8000_0000, exp=-31.
//   carry=1, sig=0x0000_0003, exp=5 -> latency 1; sig=0x8000_0001 (sticky kept); exp=6.
//   sig=0, exp=-20, neg=1 -> latency 1; out_zero=1, sig=0, exp=-20, out_neg=1.
//   sig=0x0000_0100, exp=-150 -> one fine step, floor hit; latency 2; sig=0x0000_0200, exp=-151.
//   Backpressure: out_ready low 5 cycles -> outputs stable, in_ready=0 throughout.
//     - Also: rst_n pulsed during SHIFT -> out_valid never asserts; in_ready=1 after release.

Source files
------------

// File: rtl/normalize_seq.sv
// normalize_seq: multi-cycle left-normalizer between the significand adder and
//   the round stage. Folds the adder carry-out in on load, then shifts one
//   coarse (COARSE-bit) or fine (1-bit) step per cycle until the MSB is set or
//   the exponent reaches EXP_FLOOR. Latency accept->out_valid is steps+1 cycles.
//   Accepts a new beat only while idle; holds the result until out_ready.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready high only when idle)
//   in_neg/in_carry         result sign, adder carry-out (bit INTn of raw sum)
//   in_exp/in_sig           signed exponent of in_sig[INTn-1], raw significand
//   out_valid/out_ready     output handshake to round
//   out_neg/out_exp/out_sig normalized sign, exponent, significand
//   out_zero                significand is exactly zero
module normalize_seq #(
  parameter int INTn   = 32,
  parameter int NEXP   = 8,
  parameter int NSIG   = 23,
  parameter int COARSE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_neg,
  input  logic              in_carry,
  input  logic [NEXP+1:0]   in_exp,
  input  logic [INTn-1:0]   in_sig,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_neg,
  output logic [NEXP+1:0]   out_exp,
  output logic [INTn-1:0]   out_sig,
  output logic              out_zero
);

  localparam int EW        = NEXP + 2;
  localparam int EMIN      = 2 - 2**(NEXP-1);
  localparam int EXP_FLOOR = EMIN - NSIG - 2;

  localparam logic signed [EW-1:0] FLOOR_E = EW'(EXP_FLOOR);
  // One extra bit so exp-COARSE cannot wrap before the floor comparison.
  localparam logic signed [EW:0]   FLOOR_W = (EW+1)'(EXP_FLOOR);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   neg_q;
  logic                   zero_q;
  logic signed [EW-1:0]   exp_q;
  logic [INTn-1:0]        sig_q;

  logic [INTn-1:0]        ld_sig_d;
  logic signed [EW-1:0]   ld_exp_d;
  logic signed [EW:0]     exp_m_c;
  logic                   coarse_ok;

  // Load values: a carry-out means the true MSB is bit INTn, so shift right by
  // one and keep the dropped bit as sticky in bit 0.
  always_comb begin
    ld_sig_d = in_sig;
    ld_exp_d = in_exp;
    if (in_carry) begin
      ld_sig_d    = {1'b1, in_sig[INTn-1:1]};
      ld_sig_d[0] = in_sig[1] | in_sig[0];
      ld_exp_d    = in_exp + EW'(1);
    end
  end

  // Coarse step only when it shifts out zeros and stays at or above the floor.
  always_comb begin
    exp_m_c   = {exp_q[EW-1], exp_q} - (EW+1)'(COARSE);
    coarse_ok = (sig_q[INTn-1 -: COARSE] == '0) && (exp_m_c >= FLOOR_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      exp_q       <= '0;
      sig_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sig_q      <= ld_sig_d;
            exp_q      <= ld_exp_d;
            neg_q      <= in_neg;
            zero_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (sig_q == '0) begin
            zero_q      <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (sig_q[INTn-1] || (exp_q == FLOOR_E)) begin
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else if (coarse_ok) begin
            sig_q <= sig_q << COARSE;
            exp_q <= exp_m_c[EW-1:0];
          end else begin
            sig_q <= sig_q << 1;
            exp_q <= exp_q - EW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_neg   = neg_q;
  assign out_zero  = zero_q;
  assign out_exp   = exp_q;
  assign out_sig   = sig_q;

endmodule

// File: tb/tb_normalize_seq.sv
module tb_normalize_seq;

  localparam int INTn = 32;
  localparam int EW   = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_neg = 1'b0;
  logic            in_carry = 1'b0;
  logic [EW-1:0]   in_exp = '0;
  logic [INTn-1:0] in_sig = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_neg;
  logic [EW-1:0]   out_exp;
  logic [INTn-1:0] out_sig;
  logic            out_zero;

  normalize_seq #(.INTn(32), .NEXP(8), .NSIG(23), .COARSE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_neg(in_neg), .in_carry(in_carry), .in_exp(in_exp), .in_sig(in_sig),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neg(out_neg), .out_exp(out_exp), .out_sig(out_sig), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              neg;
    bit              carry;
    int              exp;
    logic [INTn-1:0] sig;
    int              lat;
    int              oexp;
    logic [INTn-1:0] osig;
    bit              ozero;
  } vec_t;

  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  function automatic int sexp(input logic [EW-1:0] e);
    return int'($signed(e));
  endfunction

  // Present a beat at the negedge, accept it on the next posedge, then count
  // cycles until out_valid (bounded).
  task automatic send(input vec_t v, output int lat);
    bit got;
    @(negedge clk);
    chk("in_ready_before_send", in_ready, 1);
    in_neg   = v.neg;
    in_carry = v.carry;
    in_exp   = EW'(v.exp);
    in_sig   = v.sig;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Garbage on the data bus after accept must not matter.
    in_sig   = 32'hDEAD_BEEF;
    in_exp   = EW'(77);
    in_carry = 1'b1;
    in_neg   = ~v.neg;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_timeout: got no out_valid within 200 cycles, expected %0d", v.lat);
    end
  endtask

  task automatic check_out(input vec_t v, input int lat, input int idx);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_sig", idx), out_sig, v.osig);
    chk($sformatf("v%0d_exp", idx), sexp(out_exp), v.oexp);
    chk($sformatf("v%0d_neg", idx), out_neg, v.neg);
    chk($sformatf("v%0d_zero", idx), out_zero, v.ozero);
    chk($sformatf("v%0d_in_ready_hold", idx), in_ready, 0);
  endtask

  task automatic release_out(input int idx);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("r%0d_out_valid_drop", idx), out_valid, 0);
    chk($sformatf("r%0d_in_ready_back", idx), in_ready, 1);
  endtask

  initial begin
    int   lat;
    int   seen;
    vec_t bp;
    logic [INTn-1:0] s0;
    logic [EW-1:0]   e0;

    //            neg carry exp   sig            lat oexp  osig           zero
    vecs[0] = '{1'b0, 1'b0,    0, 32'h8000_0000,  1,    0, 32'h8000_0000, 1'b0};
    vecs[1] = '{1'b0, 1'b0,    0, 32'h0000_0001, 11,  -31, 32'h8000_0000, 1'b0};
    vecs[2] = '{1'b0, 1'b1,    5, 32'h0000_0003,  1,    6, 32'h8000_0001, 1'b0};
    vecs[3] = '{1'b1, 1'b0,  -20, 32'h0000_0000,  1,  -20, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b0, 1'b0, -150, 32'h0000_0100,  2, -151, 32'h0000_0200, 1'b0};
    vecs[5] = '{1'b1, 1'b1,    0, 32'h0000_0001,  1,    1, 32'h8000_0001, 1'b0};
    vecs[6] = '{1'b0, 1'b1,  127, 32'hFFFF_FFFE,  1,  128, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{1'b0, 1'b0, -140, 32'h0000_0001,  5, -151, 32'h0000_0800, 1'b0};
    vecs[8] = '{1'b1, 1'b0,   -3, 32'h4000_0000,  2,   -4, 32'h8000_0000, 1'b0};
    vecs[9] = '{1'b0, 1'b0,   10, 32'h00F0_0000,  2,    2, 32'hF000_0000, 1'b0};

    // Reset state while rst_n is held low.
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_neg", out_neg, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_exp", out_exp, 0);
    chk("rst_out_sig", out_sig, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i], lat);
      check_out(vecs[i], lat, i);
      release_out(i);
    end

    // Backpressure: hold out_ready low 5 cycles while upstream keeps offering
    // a different beat; outputs must stay put and nothing is accepted.
    bp = vecs[9];
    send(bp, lat);
    check_out(bp, lat, 90);
    s0 = out_sig;
    e0 = out_exp;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sig   = 32'h0000_0001;
      in_exp   = '0;
      in_carry = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_out_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
      chk($sformatf("bp%0d_sig", c), out_sig, bp.osig);
      chk($sformatf("bp%0d_exp", c), sexp(out_exp), bp.oexp);
    end
    chk("bp_sig_stable", out_sig, s0);
    chk("bp_exp_stable", out_exp, e0);
    @(negedge clk);
    in_valid = 1'b0;
    release_out(91);

    // Reset pulsed during SHIFT: beat discarded immediately, no out_valid.
    @(negedge clk);
    in_sig   = 32'h0000_0001;
    in_exp   = '0;
    in_carry = 1'b0;
    in_neg   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_sig", out_sig, 0);
    chk("arst_out_exp", out_exp, 0);
    chk("arst_out_neg", out_neg, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready_after_release", in_ready, 1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("arst_no_out_valid", seen, 0);

    // Normal operation resumes after the reset.
    send(vecs[1], lat);
    check_out(vecs[1], lat, 99);
    release_out(99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
